// File: rtl/cpu_flags.sv
// cpu_flags -- 6502-style processor status register plus a one-deep ALU
// result holding register.
//
// Ports:
//   clk                 system clock, all state updates on the rising edge
//   rst_n               synchronous active-low reset
//   alu_add, alu_sub    ALU operation strobes for this cycle (add wins if both)
//   alu_A, alu_B        ALU operands
//   alu_out             ALU result for this cycle
//   upd_nz/upd_c/upd_v  latch N/Z, C, V from the current ALU operation
//   set_*/clr_*, clr_v  explicit flag operations (set+clr together = neither)
//   p_load, p_in        load N,V,D,I,Z,C from a status byte (PLP/RTI)
//   brk                 value presented on p_out[4], combinational
//   res_we, res_ack     result write strobe / consumer acknowledge
//   res, res_valid      registered ALU result and its pending flag
//   p_out               {N,V,1,brk,D,I,Z,C}
//   flag_n..flag_c      individual flag outputs
module cpu_flags (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       alu_add,
   input  logic       alu_sub,
   input  logic [7:0] alu_A,
   input  logic [7:0] alu_B,
   input  logic [7:0] alu_out,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic       set_c,
   input  logic       clr_c,
   input  logic       set_i,
   input  logic       clr_i,
   input  logic       set_d,
   input  logic       clr_d,
   input  logic       clr_v,
   input  logic       p_load,
   input  logic [7:0] p_in,
   input  logic       brk,
   input  logic       res_we,
   input  logic       res_ack,
   output logic [7:0] res,
   output logic       res_valid,
   output logic [7:0] p_out,
   output logic       flag_n,
   output logic       flag_v,
   output logic       flag_d,
   output logic       flag_i,
   output logic       flag_z,
   output logic       flag_c
);

   logic       r_n, r_v, r_d, r_i, r_z, r_c;
   logic [7:0] r_res;
   logic       r_res_valid;

   logic       w_add, w_sub;
   logic [8:0] w_sum;
   logic       w_c_alu, w_v_alu;
   logic       w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;

   // Add takes precedence when both strobes are asserted.
   assign w_add = alu_add;
   assign w_sub = alu_sub & ~alu_add;
   assign w_sum = {1'b0, alu_B} + {1'b0, alu_A};

   // Carry is not-borrow for subtract; overflow from operand/result signs.
   always_comb begin
      w_c_alu = 1'b0;
      w_v_alu = 1'b0;
      if (w_add) begin
         w_c_alu = w_sum[8];
         w_v_alu = ~(alu_A[7] ^ alu_B[7]) & (alu_B[7] ^ alu_out[7]);
      end else if (w_sub) begin
         w_c_alu = (alu_B >= alu_A);
         w_v_alu = (alu_A[7] ^ alu_B[7]) & (alu_B[7] ^ alu_out[7]);
      end
   end

   // Per-flag priority: p_load, explicit set/clr, ALU update, hold.
   // A simultaneous set and clear cancels and falls through.
   always_comb begin
      w_n_nxt = r_n;
      w_v_nxt = r_v;
      w_d_nxt = r_d;
      w_i_nxt = r_i;
      w_z_nxt = r_z;
      w_c_nxt = r_c;
      if (p_load) begin
         w_n_nxt = p_in[7];
         w_v_nxt = p_in[6];
         w_d_nxt = p_in[3];
         w_i_nxt = p_in[2];
         w_z_nxt = p_in[1];
         w_c_nxt = p_in[0];
      end else begin
         if (upd_nz) begin
            w_n_nxt = alu_out[7];
            w_z_nxt = (alu_out == 8'h00);
         end

         if (set_c ^ clr_c)
            w_c_nxt = set_c;
         else if (upd_c && (w_add || w_sub))
            w_c_nxt = w_c_alu;

         if (clr_v)
            w_v_nxt = 1'b0;
         else if (upd_v && (w_add || w_sub))
            w_v_nxt = w_v_alu;

         if (set_d ^ clr_d)
            w_d_nxt = set_d;
         if (set_i ^ clr_i)
            w_i_nxt = set_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_n         <= 1'b0;
         r_v         <= 1'b0;
         r_d         <= 1'b0;
         r_i         <= 1'b1;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_n <= w_n_nxt;
         r_v <= w_v_nxt;
         r_d <= w_d_nxt;
         r_i <= w_i_nxt;
         r_z <= w_z_nxt;
         r_c <= w_c_nxt;
         // A write always wins over an acknowledge so new data is never lost.
         if (res_we) begin
            r_res       <= alu_out;
            r_res_valid <= 1'b1;
         end else if (res_ack) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign res       = r_res;
   assign res_valid = r_res_valid;
   assign p_out     = {r_n, r_v, 1'b1, brk, r_d, r_i, r_z, r_c};
   assign flag_n    = r_n;
   assign flag_v    = r_v;
   assign flag_d    = r_d;
   assign flag_i    = r_i;
   assign flag_z    = r_z;
   assign flag_c    = r_c;

endmodule

// File: doc/cpu_flags.md
CPU_FLAGS -- requirements
Module: cpu_flags

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: alu_add, alu_sub  in  1 each  same op strobes driven to the ALU this cycle.
REQ-004 SHALL have: alu_A, alu_B, alu_out  in  8 each  ALU operands and ALU result, same cycle.
REQ-005 SHALL have: upd_nz, upd_c, upd_v  in  1 each  latch N/Z, C, V from ALU.
REQ-006 SHALL have: set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v  in  1 each  explicit flag ops.
REQ-007 SHALL have: p_load  in  1  load status from p_in (PLP/RTI).
REQ-008 SHALL have: p_in  in  8  status value from data bus.
REQ-009 SHALL have: brk  in  1  value driven on p_out bit 4 (combinational).
REQ-010 SHALL have: res_we, res_ack  in  1 each  result write strobe / consumer acknowledge.
REQ-011 SHALL have: res  out  8  registered ALU result; res_valid  out  1  result pending.
REQ-012 SHALL have: p_out  out  8  {N,V,1,brk,D,I,Z,C}; flag_n, flag_v, flag_d, flag_i, flag_z, flag_c  out  1 each.

Function
REQ-013 All state (N,V,D,I,Z,C, res, res_valid) SHALL update only on rising clk; outputs direct from registers except p_out bit 4.
REQ-014 upd_nz SHALL load N=alu_out[7], Z=(alu_out==0).
REQ-015 upd_c with alu_add SHALL load C = bit 8 of {1'b0,alu_B}+{1'b0,alu_A}; no carry-in.
REQ-016 upd_c with alu_sub SHALL load C = (alu_B >= alu_A), unsigned (6502 not-borrow).
REQ-017 upd_c with neither alu_add nor alu_sub SHALL leave C unchanged.
REQ-018 upd_v with alu_add SHALL load V = ~(A[7]^B[7]) & (B[7]^out[7]); with alu_sub V = (A[7]^B[7]) & (B[7]^out[7]); otherwise V unchanged.
REQ-019 alu_add and alu_sub both high SHALL be treated as alu_add.
REQ-020 Per-flag priority, highest first: p_load; explicit set/clr; upd_*; hold.
REQ-021 set_x and clr_x both high SHALL count as neither; the flag falls to upd_* or hold.
REQ-022 p_load SHALL load N,V,D,I,Z,C from p_in[7,6,3,2,1,0]; p_in[5:4] ignored; all same-cycle set/clr/upd ignored.
REQ-023 D and I SHALL change only via set/clr/p_load.
REQ-024 Flag changes SHALL be visible on outputs the cycle after the strobe (latency 1).
REQ-025 res_we SHALL load res=alu_out and set res_valid=1 next cycle.
REQ-026 res_ack with res_we low SHALL clear res_valid; res holds its value.
REQ-027 res_we and res_ack together SHALL load new res with res_valid=1 (overwrite, no loss of new data).
REQ-028 res_ack while res_valid=0 SHALL be a no-op; res_we while res_valid=1 SHALL overwrite.

Reset
REQ-029 rst_n=0 at rising clk SHALL force N=V=D=Z=C=0, I=1, res=0x00, res_valid=0, overriding every other input.
REQ-030 Reset SHALL take effect only on a clock edge; rst_n low between edges SHALL not alter outputs.
REQ-031 After reset with brk=0, p_out SHALL read 0x24.

Verification
REQ-032 Reset, then alu_add, A=0x50, B=0x50, out=0xA0, upd_nz/upd_c/upd_v -> N=1 V=1 Z=0 C=0, p_out=0xE4.
REQ-033 alu_sub, A=0x01, B=0x01, out=0x00, all upd -> Z=1 C=1 N=0 V=0, p_out=0x27; then alu_sub, A=0x02, B=0x01, out=0xFF, upd_c -> C=0.
REQ-034 p_load, p_in=0xFF, clr_c+upd_nz same cycle, brk=0 -> p_out=0xEF; next cycle set_c+clr_c+upd_c with alu_add, A=B=0x01 -> C=0.
REQ-035 res_we, out=0x3C -> res=0x3C, valid=1; res_we+res_ack, out=0x7E -> res=0x7E, valid=1; res_ack alone -> valid=0, res=0x7E.
REQ-036 Mid-sequence rst_n=0 with upd_*, set_c, res_we, p_load all high -> next edge p_out=0x24, res=0x00, valid=0; rst_n pulsed low between edges -> no change.
